fir_l3_output_serializer: RTL and testbench

//  Output-side companion of the 3-parallel (L=3) FIR block.
//  - Captures one 3-lane result word (y0,y1,y2) per cycle when in_valid is high.
//  - Buffers words in a small FIFO.
//  - Re-emits them as a single-sample stream with a valid/ready handshake.
//  - Emission order is time order: y2 (oldest), then y1, then y0 (newest).
//  - The FIR has no backpressure, so this block absorbs bursts and flags overflow.

---
 rtl/fir_l3_output_serializer.sv | 114 +++++++++++
 tb/tb_fir_l3_output_serializer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_l3_output_serializer.sv
// Output serializer for the 3-parallel FIR: buffers 3-lane result words in a FIFO
// and re-emits them one sample per transfer in time order (y2, y1, y0).
module fir_l3_output_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_y0,
  input  logic [DATA_WIDTH-1:0]   in_y1,
  input  logic [DATA_WIDTH-1:0]   in_y2,
  input  logic                    flush,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {
    LANE_Y2 = 2'd0,
    LANE_Y1 = 2'd1,
    LANE_Y0 = 2'd2
  } lane_e;

  lane_e           lane_q, lane_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [WW-1:0]   mem_q [DEPTH];
  logic [WW-1:0]   head_word;

  logic empty, full;
  logic xfer, pop, push_req, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Flush overrides both sides of the FIFO, so it gates transfer and push here.
  assign xfer     = !empty && out_ready && !flush;
  assign pop      = xfer && (lane_q == LANE_Y0);
  assign push_req = in_valid && !flush;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;

  always_comb begin
    lane_d   = lane_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    if (flush) begin
      lane_d   = LANE_Y2;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (xfer) begin
        case (lane_q)
          LANE_Y2: lane_d = LANE_Y1;
          LANE_Y1: lane_d = LANE_Y0;
          default: lane_d = LANE_Y2;
        endcase
      end
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    end

    // A fresh drop takes priority over a same-edge clear.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= LANE_Y2;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_y2, in_y1, in_y0};
  end

  assign head_word = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    out_data = '0;
    if (!empty) begin
      case (lane_q)
        LANE_Y2: out_data = head_word[3*DATA_WIDTH-1:2*DATA_WIDTH];
        LANE_Y1: out_data = head_word[2*DATA_WIDTH-1:DATA_WIDTH];
        default: out_data = head_word[DATA_WIDTH-1:0];
      endcase
    end
  end

  assign out_valid = !empty;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_l3_output_serializer.sv
// Self-checking bench for fir_l3_output_serializer against a queue-based word model.
module tb_fir_l3_output_serializer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_y0, in_y1, in_y2;
  logic          flush, ovf_clr;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    level;
  logic          overflow;

  fir_l3_output_serializer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_y0    (in_y0),
    .in_y1    (in_y1),
    .in_y2    (in_y2),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;
    logic [DW-1:0] y2;
  } word_t;

  // Reference: a queue of whole words plus the index of the next sample to emit.
  word_t mq[$];
  int    m_lane;
  bit    m_ovf;

  int tests_run = 0;
  int failed    = 0;

  function automatic logic [DW-1:0] exp_data();
    if (mq.size() == 0) return '0;
    if (m_lane == 0) return mq[0].y2;
    if (m_lane == 1) return mq[0].y1;
    return mq[0].y0;
  endfunction

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [3:0] exp_level();
    return 4'(mq.size());
  endfunction

  task automatic model_update();
    bit was_full, popped, dropped;
    word_t w;
    was_full = (mq.size() == DEPTH);
    popped   = 0;
    dropped  = 0;
    if (flush) begin
      mq.delete();
      m_lane = 0;
    end else begin
      if (mq.size() > 0 && out_ready) begin
        if (m_lane == 2) begin
          popped = 1;
          m_lane = 0;
          void'(mq.pop_front());
        end else begin
          m_lane++;
        end
      end
      if (in_valid) begin
        if (!was_full || popped) begin
          w.y0 = in_y0; w.y1 = in_y1; w.y2 = in_y2;
          mq.push_back(w);
        end else begin
          dropped = 1;
        end
      end
    end
    if (dropped)      m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; ovf_clr = 0; out_ready = 0;
    in_y0 = '0; in_y1 = '0; in_y2 = '0;
  endtask

  task automatic rand_word();
    in_y0 = DW'($urandom); in_y1 = DW'($urandom); in_y2 = DW'($urandom);
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    mq.delete(); m_lane = 0; m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || level !== 4'd0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL reset: got valid=%b data=%h level=%0d ovf=%b, expected 0/0000/0/0",
               out_valid, out_data, level, overflow);
    end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] want [3];
    want[0] = 16'h0003; want[1] = 16'h0002; want[2] = 16'h0001;
    in_valid = 1; in_y0 = 16'h0001; in_y1 = 16'h0002; in_y2 = 16'h0003; out_ready = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== want[k]) begin
        failed++;
        $display("FAIL single_word[%0d]: got valid=%b data=%h, expected 1/%h", k, out_valid, out_data, want[k]);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failed++;
      $display("FAIL single_word_end: got valid=%b data=%h, expected 0/0000", out_valid, out_data);
    end
  endtask

  task automatic test_stall();
    in_valid = 1; in_y0 = 16'h0001; in_y1 = 16'h0002; in_y2 = 16'h0003; out_ready = 0;
    tick();
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'h0003 || level !== 4'd1) begin
        failed++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h level=%0d, expected 1/0003/1",
                 k, out_valid, out_data, level);
      end
      tick();
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (out_valid !== exp_valid() || out_data !== exp_data()) begin
        failed++;
        $display("FAIL stall_release[%0d]: got valid=%b data=%h, expected %b/%h",
                 k, out_valid, out_data, exp_valid(), exp_data());
      end
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_overflow_drain();
    int k;
    out_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1; in_y0 = DW'(i); in_y1 = DW'($urandom); in_y2 = DW'($urandom);
      tick();
    end
    in_valid = 0;
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL overflow_fill: got level=%0d ovf=%b, expected 8/1", level, overflow);
    end
    out_ready = 1;
    k = 0;
    while (out_valid && k < 40) begin
      tests_run++;
      if (out_data !== exp_data()) begin
        failed++;
        $display("FAIL overflow_drain[%0d]: got %h expected %h", k, out_data, exp_data());
      end
      if (k % 3 == 2) begin
        tests_run++;
        if (out_data !== DW'(k / 3 + 1)) begin
          failed++;
          $display("FAIL overflow_order[%0d]: got %h expected %h", k, out_data, DW'(k / 3 + 1));
        end
      end
      tick();
      k++;
    end
    tests_run++;
    if (k != 24 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL overflow_count: got %0d samples (valid=%b), expected 24 then idle", k, out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_full_passthrough();
    flush = 1; ovf_clr = 1;
    tick();
    flush = 0; ovf_clr = 0; out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; rand_word();
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (2) tick();
    tests_run++;
    if (level !== 4'd8 || out_data !== exp_data() || overflow !== 1'b0) begin
      failed++;
      $display("FAIL full_setup: got level=%0d data=%h ovf=%b, expected 8/%h/0",
               level, out_data, overflow, exp_data());
    end
    in_valid = 1; rand_word();
    tick();
    in_valid = 0; out_ready = 0;
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b0 || out_data !== exp_data()) begin
      failed++;
      $display("FAIL full_push_pop: got level=%0d ovf=%b data=%h, expected 8/0/%h",
               level, overflow, out_data, exp_data());
    end
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; rand_word();
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (9) tick();
    out_ready = 0;
    tests_run++;
    if (level !== 4'd5 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL flush_setup: got level=%0d ovf=%b, expected 5/1", level, overflow);
    end
    flush = 1; in_valid = 1; out_ready = 1; rand_word();
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    tests_run++;
    if (level !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL flush: got level=%0d valid=%b ovf=%b, expected 0/0/1", level, out_valid, overflow);
    end
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    tests_run++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL ovf_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] y2_new;
    in_valid = 1; rand_word(); out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    tests_run++;
    if (out_data !== exp_data() || m_lane != 1) begin
      failed++;
      $display("FAIL areset_setup: got %h expected %h", out_data, exp_data());
    end
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== '0) begin
      failed++;
      $display("FAIL areset_immediate: got valid=%b level=%0d data=%h, expected 0/0/0000",
               out_valid, level, out_data);
    end
    @(negedge clk);
    rst_n = 1;
    mq.delete(); m_lane = 0; m_ovf = 0;
    in_valid = 1; rand_word(); y2_new = in_y2; out_ready = 0;
    tick();
    in_valid = 0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== y2_new) begin
      failed++;
      $display("FAIL areset_after: got valid=%b data=%h, expected 1/%h", out_valid, out_data, y2_new);
    end
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 99) < 45);
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 63) == 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      rand_word();
      tick();
      tests_run++;
      if (out_valid !== exp_valid() || out_data !== exp_data() ||
          level !== exp_level() || overflow !== m_ovf) begin
        failed++;
        $display("FAIL random[%0d]: got v=%b d=%h l=%0d o=%b, expected v=%b d=%h l=%0d o=%b",
                 c, out_valid, out_data, level, overflow,
                 exp_valid(), exp_data(), exp_level(), m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    mq.delete(); m_lane = 0; m_ovf = 0;
    test_reset();
    test_single_word();
    test_stall();
    test_overflow_drain();
    test_full_passthrough();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
